lbist_lfsr: RTL and testbench



---
 rtl/lbist_lfsr.sv | 110 +++++++++++
 tb/tb_lbist_lfsr.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lbist_lfsr.sv
// Fibonacci LFSR pattern generator for the logic-BIST controller: one maximal-length N-bit step per enabled clock.
// Optional macro LFSR_SEED_PORT_EN adds a synchronous seed-load port (seed_load/seed).
module lbist_lfsr #(
  parameter int unsigned N    = 20,
  parameter logic [31:0] SEED = 32'd1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
`ifdef LFSR_SEED_PORT_EN
  input  logic         seed_load,
  input  logic [N-1:0] seed,
`endif
  output logic [N-1:0] dout
);

  // Build a 32-bit mask from up to four 1-indexed tap positions (0 = unused slot).
  function automatic logic [31:0] taps4(input logic [5:0] a, input logic [5:0] b,
                                        input logic [5:0] c, input logic [5:0] d);
    logic [31:0] m;
    m = 32'h0000_0000;
    if (a != 6'd0) m[a - 6'd1] = 1'b1; else m = m;
    if (b != 6'd0) m[b - 6'd1] = 1'b1; else m = m;
    if (c != 6'd0) m[c - 6'd1] = 1'b1; else m = m;
    if (d != 6'd0) m[d - 6'd1] = 1'b1; else m = m;
    return m;
  endfunction

  function automatic logic [N-1:0] tap_mask();
    logic [31:0] m;
    case (N)
      32'd3:   m = taps4(6'd3,  6'd2,  6'd0, 6'd0);
      32'd4:   m = taps4(6'd4,  6'd3,  6'd0, 6'd0);
      32'd5:   m = taps4(6'd5,  6'd3,  6'd0, 6'd0);
      32'd6:   m = taps4(6'd6,  6'd5,  6'd0, 6'd0);
      32'd7:   m = taps4(6'd7,  6'd6,  6'd0, 6'd0);
      32'd8:   m = taps4(6'd8,  6'd6,  6'd5, 6'd4);
      32'd9:   m = taps4(6'd9,  6'd5,  6'd0, 6'd0);
      32'd10:  m = taps4(6'd10, 6'd7,  6'd0, 6'd0);
      32'd11:  m = taps4(6'd11, 6'd9,  6'd0, 6'd0);
      32'd12:  m = taps4(6'd12, 6'd6,  6'd4, 6'd1);
      32'd13:  m = taps4(6'd13, 6'd4,  6'd3, 6'd1);
      32'd14:  m = taps4(6'd14, 6'd5,  6'd3, 6'd1);
      32'd15:  m = taps4(6'd15, 6'd14, 6'd0, 6'd0);
      32'd16:  m = taps4(6'd16, 6'd15, 6'd13, 6'd4);
      32'd17:  m = taps4(6'd17, 6'd14, 6'd0, 6'd0);
      32'd18:  m = taps4(6'd18, 6'd11, 6'd0, 6'd0);
      32'd19:  m = taps4(6'd19, 6'd6,  6'd2, 6'd1);
      32'd20:  m = taps4(6'd20, 6'd17, 6'd0, 6'd0);
      32'd21:  m = taps4(6'd21, 6'd19, 6'd0, 6'd0);
      32'd22:  m = taps4(6'd22, 6'd21, 6'd0, 6'd0);
      32'd23:  m = taps4(6'd23, 6'd18, 6'd0, 6'd0);
      32'd24:  m = taps4(6'd24, 6'd23, 6'd22, 6'd17);
      32'd25:  m = taps4(6'd25, 6'd22, 6'd0, 6'd0);
      32'd26:  m = taps4(6'd26, 6'd6,  6'd2, 6'd1);
      32'd27:  m = taps4(6'd27, 6'd5,  6'd2, 6'd1);
      32'd28:  m = taps4(6'd28, 6'd25, 6'd0, 6'd0);
      32'd29:  m = taps4(6'd29, 6'd27, 6'd0, 6'd0);
      32'd30:  m = taps4(6'd30, 6'd6,  6'd4, 6'd1);
      32'd31:  m = taps4(6'd31, 6'd28, 6'd0, 6'd0);
      32'd32:  m = taps4(6'd32, 6'd22, 6'd2, 6'd1);
      default: m = 32'h0000_0000;
    endcase
    return m[N-1:0];
  endfunction

  if ((N < 32'd3) || (N > 32'd32)) begin : g_bad_width
    $error("lbist_lfsr: N must be in 3..32");
  end

  localparam logic [N-1:0] TAPS     = tap_mask();
  localparam logic [N-1:0] ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] SEED_N   = SEED[N-1:0];
  // An all-zero seed would lock the XOR feedback, so it is replaced by 1.
  localparam logic [N-1:0] EFF_SEED = (SEED_N == {N{1'b0}}) ? ONE_N : SEED_N;

  logic [N-1:0] s_r;
  logic [N-1:0] s_next_s;
  logic         fb_s;

  // Next-state selection: seed load, lock-up recovery, shift, or hold.
  always_comb begin
    s_next_s = s_r;
    fb_s     = ^(s_r & TAPS);
`ifdef LFSR_SEED_PORT_EN
    if (seed_load) begin
      s_next_s = (seed == {N{1'b0}}) ? ONE_N : seed;
    end else
`endif
    if (s_r == {N{1'b0}}) begin
      s_next_s = ONE_N;
    end else if (en) begin
      s_next_s = {s_r[N-2:0], fb_s};
    end else begin
      s_next_s = s_r;
    end
  end

  // State register with asynchronous reset to the effective seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_r <= EFF_SEED;
    end else begin
      s_r <= s_next_s;
    end
  end

  assign dout = s_r;

endmodule

// File: tb/tb_lbist_lfsr.sv
// Self-checking bench for lbist_lfsr: vector table, multi-cycle corner cases and a randomized run
// against a tap-list reference model for N=20, N=5 and N=8 (SEED=0).
module tb_lbist_lfsr;

  logic        clk;
  logic        rst;
  logic        en;
  logic [19:0] dout20;
  logic [4:0]  dout5;
  logic [7:0]  dout8;
`ifdef LFSR_SEED_PORT_EN
  logic        seed_load;
  logic [19:0] seed20;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int taps20[$] = '{20, 17};
  int taps5[$]  = '{5, 3};
  int taps8[$]  = '{8, 6, 5, 4};

  lbist_lfsr #(.N(20), .SEED(32'd1)) u20 (
    .clk(clk), .rst(rst), .en(en),
`ifdef LFSR_SEED_PORT_EN
    .seed_load(seed_load), .seed(seed20),
`endif
    .dout(dout20));
  lbist_lfsr #(.N(5), .SEED(32'd1)) u5 (
    .clk(clk), .rst(rst), .en(en),
`ifdef LFSR_SEED_PORT_EN
    .seed_load(1'b0), .seed(5'd0),
`endif
    .dout(dout5));
  lbist_lfsr #(.N(8), .SEED(32'd0)) u8 (
    .clk(clk), .rst(rst), .en(en),
`ifdef LFSR_SEED_PORT_EN
    .seed_load(1'b0), .seed(8'd0),
`endif
    .dout(dout8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: feedback is the parity of the tapped (1-indexed) bits, new bit enters at the bottom.
  function automatic longint unsigned model_step(longint unsigned s, int n, int taps[$]);
    longint unsigned fb;
    if (s == 0) return 1;
    fb = 0;
    foreach (taps[i]) fb = fb ^ ((s >> (taps[i] - 1)) & 1);
    return (s * 2 + fb) % (64'd1 << n);
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #3 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    int          steps;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    longint unsigned m20, m5, m8;
    int cnt;
    bit seen[32];
    int dup;

    rst = 1'b0;
    en  = 1'b0;
`ifdef LFSR_SEED_PORT_EN
    seed_load = 1'b0;
    seed20    = 20'd0;
`endif
    vecs[0] = '{0,  20'h00001};
    vecs[1] = '{1,  20'h00002};
    vecs[2] = '{16, 20'h10000};
    vecs[3] = '{17, 20'h20001};
    vecs[4] = '{18, 20'h40002};

    // Reset values, including the zero-seed substitution.
    do_reset();
    rst = 1'b1;
    #2;
    chk("reset_n20", dout20, 64'h1);
    chk("reset_n5", dout5, 64'h1);
    chk("reset_n8_seed0", dout8, 64'h1);
    en = 1'b1;
    tick();
    chk("reset_hold_en", dout20, 64'h1);
    rst = 1'b0;

    // Vector table: dout after k enabled clocks from release.
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      while (cnt < vecs[i].steps) begin
        tick();
        cnt++;
      end
      chk($sformatf("vec_step%0d", vecs[i].steps), dout20, vecs[i].exp);
    end

    // Enable gap: hold exactly, then continue the same sequence.
    do_reset();
    en = 1'b1;
    m20 = 1;
    tick(); m20 = model_step(m20, 20, taps20);
    tick(); m20 = model_step(m20, 20, taps20);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_frozen", dout20, m20);
    end
    en = 1'b1;
    tick(); m20 = model_step(m20, 20, taps20);
    chk("gap_resume", dout20, m20);

    // N=5 period: first return to 1 after exactly 31 clocks, every nonzero value once.
    do_reset();
    en = 1'b1;
    cnt = 0;
    dup = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    seen[1] = 1'b1;
    do begin
      tick();
      cnt++;
      if (dout5 != 5'd1) begin
        if (seen[dout5]) dup++;
        seen[dout5] = 1'b1;
      end
    end while (dout5 != 5'd1 && cnt < 40);
    chk("period_n5", cnt, 31);
    chk("period_dups", dup, 0);
    chk("period_zero_seen", seen[0], 0);
    cnt = 0;
    for (int i = 1; i < 32; i++) cnt += seen[i];
    chk("period_all_seen", cnt, 31);

    // Async reset between edges restores the seed before the next edge.
    tick(); tick(); tick();
    #3 rst = 1'b1;
    #1;
    chk("async_rst_n20", dout20, 64'h1);
    chk("async_rst_n8", dout8, 64'h1);
    tick();
    rst = 1'b0;
    tick();
    chk("restart_step1", dout20, 64'h2);

`ifdef LFSR_SEED_PORT_EN
    seed_load = 1'b1;
    seed20    = 20'hABCDE;
    tick();
    chk("seed_load", dout20, 64'hABCDE);
    seed20 = 20'd0;
    tick();
    chk("seed_zero", dout20, 64'h1);
    seed_load = 1'b0;
`endif

    // Randomized enable pattern against the model for all widths.
    do_reset();
    m20 = 1; m5 = 1; m8 = 1;
    for (int i = 0; i < 300; i++) begin
      en = 1'($urandom_range(0, 1));
      tick();
      if (en) begin
        m20 = model_step(m20, 20, taps20);
        m5  = model_step(m5, 5, taps5);
        m8  = model_step(m8, 8, taps8);
      end
      chk("rand_n20", dout20, m20);
      chk("rand_n5", dout5, m5);
      chk("rand_n8", dout8, m8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
